// File: rtl/inst_fetch_sram_pkg.sv
// Shared definitions for the instruction-fetch SRAM responder: state encoding,
// SRAM control levels, constant words and the fetch-window range check.
package inst_fetch_sram_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned SRAM_AW = 20;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } state_e;

    localparam logic ENABLE_N  = 1'b0;
    localparam logic DISABLE_N = 1'b1;

    localparam logic [WORD_W-1:0] ZERO_WORD = 32'h0000_0000;
    localparam logic [WORD_W-1:0] NOP_WORD  = 32'h0000_0000;

    // 33-bit compare so base + 4*words cannot wrap past 2^32.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input int unsigned words);
        logic [32:0] w_lo;
        logic [32:0] w_hi;
        w_lo = {1'b0, base};
        w_hi = w_lo + (33'(words) << 2);
        return ({1'b0, addr} >= w_lo) && ({1'b0, addr} < w_hi);
    endfunction

endpackage

// File: rtl/inst_fetch_sram_if.sv
// PC-side fetch handshake between the PC stage (master) and the SRAM responder (slave).
interface inst_fetch_sram_if;
    import inst_fetch_sram_pkg::*;

    logic              req_i;
    logic [WORD_W-1:0] addr_i;
    logic              flush_i;
    logic              rdy_o;
    logic [WORD_W-1:0] inst_o;
    logic              err_o;
    logic              stall_o;

    modport master (
        output req_i, addr_i, flush_i,
        input  rdy_o, inst_o, err_o, stall_o
    );

    modport slave (
        input  req_i, addr_i, flush_i,
        output rdy_o, inst_o, err_o, stall_o
    );

endinterface

// File: rtl/inst_fetch_sram.sv
// Instruction-fetch responder: reads one 32-bit word from base SRAM per request,
// holding ce_n/oe_n low for WAIT_CYCLES, and returns it with a one-cycle ready pulse.
module inst_fetch_sram
    import inst_fetch_sram_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned RAM_WORDS   = 1048576
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    inst_fetch_sram_if.slave        fetch,
    output logic [SRAM_AW-1:0]      base_ram_addr_o,
    input  logic [WORD_W-1:0]       base_ram_data_i,
    output logic                    base_ram_ce_n_o,
    output logic                    base_ram_oe_n_o,
    output logic                    base_ram_we_n_o,
    output logic [3:0]              base_ram_be_n_o
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);

    state_e              r_state, w_state_d;
    logic [CNT_W-1:0]    r_cnt, w_cnt_d;
    logic [WORD_W-1:0]   r_inst, w_inst_d;
    logic                r_err, w_err_d;
    logic [SRAM_AW-1:0]  r_addr, w_addr_d;
    logic                r_en_n, w_en_n_d;
    logic                w_addr_ok;

    assign w_addr_ok = (fetch.addr_i[1:0] == 2'b00) &&
                       addr_in_range(fetch.addr_i, BASE_ADDR, RAM_WORDS);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_inst  <= NOP_WORD;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_en_n  <= DISABLE_N;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_inst  <= w_inst_d;
            r_err   <= w_err_d;
            r_addr  <= w_addr_d;
            r_en_n  <= w_en_n_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_inst_d  = r_inst;
        w_err_d   = r_err;
        w_addr_d  = r_addr;
        w_en_n_d  = r_en_n;
        unique case (r_state)
            StIdle: begin
                if (fetch.flush_i) begin
                    w_state_d = StIdle;
                end else if (fetch.req_i) begin
                    if (!w_addr_ok) begin
                        w_err_d   = 1'b1;
                        w_inst_d  = ZERO_WORD;
                        w_state_d = StDone;
                    end else begin
                        w_addr_d  = SRAM_AW'((fetch.addr_i - BASE_ADDR) >> 2);
                        w_en_n_d  = ENABLE_N;
                        w_cnt_d   = CNT_INIT;
                        w_state_d = StAccess;
                    end
                end
            end
            StAccess: begin
                if (fetch.flush_i) begin
                    w_en_n_d  = DISABLE_N;
                    w_state_d = StIdle;
                end else if (r_cnt != '0) begin
                    w_cnt_d = r_cnt - CNT_W'(1);
                end else begin
                    w_inst_d  = base_ram_data_i;
                    w_err_d   = 1'b0;
                    w_en_n_d  = DISABLE_N;
                    w_state_d = StDone;
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_en_n_d  = DISABLE_N;
                w_state_d = StIdle;
            end
        endcase
    end

    // A flush in the DONE cycle swallows the pulse; the PC is being redirected anyway.
    assign fetch.rdy_o   = (r_state == StDone) && !fetch.flush_i;
    assign fetch.stall_o = fetch.req_i && !fetch.rdy_o;
    assign fetch.inst_o  = r_inst;
    assign fetch.err_o   = r_err;

    assign base_ram_addr_o = r_addr;
    assign base_ram_ce_n_o = r_en_n;
    assign base_ram_oe_n_o = r_en_n;
    assign base_ram_we_n_o = 1'b1;
    assign base_ram_be_n_o = 4'b0000;

endmodule

// File: tb/tb_inst_fetch_sram.sv
// Self-checking bench for inst_fetch_sram: reset, table-driven fetches, random fetches
// against a spec-level model, and hand sequences for back-to-back, flush and async reset.
module tb_inst_fetch_sram;

    localparam int unsigned W     = 2;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int unsigned WORDS = 1048576;

    logic        clk;
    logic        rst_n;
    logic [19:0] ram_addr;
    logic [31:0] ram_data;
    logic        ram_ce_n, ram_oe_n, ram_we_n;
    logic [3:0]  ram_be_n;

    int n_checks = 0;
    int n_err    = 0;

    inst_fetch_sram_if bus ();

    inst_fetch_sram #(
        .WAIT_CYCLES (W),
        .BASE_ADDR   (BASE),
        .RAM_WORDS   (WORDS)
    ) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .fetch           (bus),
        .base_ram_addr_o (ram_addr),
        .base_ram_data_i (ram_data),
        .base_ram_ce_n_o (ram_ce_n),
        .base_ram_oe_n_o (ram_oe_n),
        .base_ram_we_n_o (ram_we_n),
        .base_ram_be_n_o (ram_be_n)
    );

    function automatic logic [31:0] mem_word(input logic [19:0] a);
        if (a == 20'd4) return 32'h2402_0005;
        return {a[11:0], a} ^ 32'h1357_9BDF;
    endfunction

    // SRAM drives data only while selected.
    assign ram_data = (!ram_ce_n && !ram_oe_n) ? mem_word(ram_addr) : 32'hDEAD_BEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: fault iff misaligned or outside the SRAM window.
    task automatic model(input logic [31:0] a, output logic err, output logic [31:0] inst,
                         output int lat, output int ce_cyc, output logic [19:0] wa);
        longint unsigned la;
        la = longint'(a);
        err = (la % 4 != 0) || (la < longint'(BASE)) || (la >= longint'(BASE) + 4 * WORDS);
        wa = err ? 20'd0 : 20'((la - longint'(BASE)) / 4);
        inst = err ? 32'h0 : mem_word(wa);
        lat = err ? 1 : W + 1;
        ce_cyc = err ? 0 : W;
    endtask

    // Called right after a negedge; the following posedge accepts the request.
    task automatic do_fetch(input logic [31:0] a, output int lat, output logic err,
                            output logic [31:0] inst, output int ce_cyc,
                            output logic [19:0] wa, output logic stall_ok);
        bit done;
        done = 0;
        lat = 0;
        ce_cyc = 0;
        wa = 20'd0;
        stall_ok = 1'b1;
        err = 1'b0;
        inst = 32'h0;
        bus.req_i = 1'b1;
        bus.addr_i = a;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
            bus.addr_i = $urandom;
            if (!ram_ce_n) begin
                ce_cyc++;
                wa = ram_addr;
            end
            if (bus.rdy_o) begin
                done = 1;
                err = bus.err_o;
                inst = bus.inst_o;
                if (bus.stall_o !== 1'b0) stall_ok = 1'b0;
            end else if (bus.stall_o !== 1'b1) begin
                stall_ok = 1'b0;
            end
        end
        bus.req_i = 1'b0;
        if (!done) lat = -1;
    endtask

    task automatic fetch_and_check(input string nm, input logic [31:0] a);
        int lat, ce_cyc, e_lat, e_ce;
        logic err, e_err, st_ok;
        logic [31:0] inst, e_inst;
        logic [19:0] wa, e_wa;
        model(a, e_err, e_inst, e_lat, e_ce, e_wa);
        do_fetch(a, lat, err, inst, ce_cyc, wa, st_ok);
        chk({nm, ".latency"}, 32'(lat), 32'(e_lat));
        if (lat >= 0) begin
            chk({nm, ".err"}, {31'd0, err}, {31'd0, e_err});
            chk({nm, ".inst"}, inst, e_inst);
            chk({nm, ".ce_cycles"}, 32'(ce_cyc), 32'(e_ce));
            chk({nm, ".stall"}, {31'd0, st_ok}, 32'd1);
            if (!e_err) chk({nm, ".ram_addr"}, {12'd0, wa}, {12'd0, e_wa});
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        exp_err;
        logic [31:0] exp_inst;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int c_rdy[$];
        logic [31:0] w_rdy[$];

        vecs[0] = '{32'h8000_0010, 1'b0, 32'h2402_0005, W + 1};
        vecs[1] = '{32'h8000_0002, 1'b1, 32'h0, 1};
        vecs[2] = '{32'h8040_0000, 1'b1, 32'h0, 1};
        vecs[3] = '{32'h7FFF_FFFC, 1'b1, 32'h0, 1};
        vecs[4] = '{32'h803F_FFFC, 1'b0, 32'h5A8A_64DF ^ 32'h0000_0000, W + 1};
        vecs[5] = '{32'h8000_0000, 1'b0, 32'h1357_9BDF, W + 1};
        vecs[6] = '{32'hFFFF_FFFC, 1'b1, 32'h0, 1};
        // Last word: {12'hFFF, 20'hFFFFF} ^ 32'h13579BDF
        vecs[4].exp_inst = 32'hECA8_6420;

        rst_n = 1'b0;
        bus.req_i = 1'b1;
        bus.addr_i = 32'h8000_0010;
        bus.flush_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset.ce_n", {31'd0, ram_ce_n}, 32'd1);
        chk("reset.oe_n", {31'd0, ram_oe_n}, 32'd1);
        chk("reset.rdy", {31'd0, bus.rdy_o}, 32'd0);
        chk("reset.inst", bus.inst_o, 32'h0);
        chk("reset.err", {31'd0, bus.err_o}, 32'd0);
        chk("reset.stall", {31'd0, bus.stall_o}, 32'd1);
        chk("reset.we_n", {31'd0, ram_we_n}, 32'd1);
        chk("reset.be_n", {28'd0, ram_be_n}, 32'd0);
        rst_n = 1'b1;
        bus.req_i = 1'b0;
        @(negedge clk);

        // Table-driven fetches with expectations written out by hand.
        for (int i = 0; i < 7; i++) begin
            int lat, ce_cyc;
            logic err, st_ok;
            logic [31:0] inst;
            logic [19:0] wa;
            do_fetch(vecs[i].addr, lat, err, inst, ce_cyc, wa, st_ok);
            chk($sformatf("vec%0d.latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("vec%0d.err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
            chk($sformatf("vec%0d.inst", i), inst, vecs[i].exp_inst);
            chk($sformatf("vec%0d.ce_cycles", i), 32'(ce_cyc), vecs[i].exp_err ? 32'd0 : 32'(W));
            if (i == 0) chk("vec0.ram_addr", {12'd0, wa}, 32'd4);
            @(negedge clk);
        end

        // Back-to-back with req held: pulses at cycles 3 and 7.
        bus.req_i = 1'b1;
        bus.addr_i = 32'h8000_0000;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (bus.rdy_o) begin
                c_rdy.push_back(cyc);
                w_rdy.push_back(bus.inst_o);
                bus.addr_i = bus.addr_i + 32'd4;
                if (c_rdy.size() == 2) bus.req_i = 1'b0;
            end
        end
        bus.req_i = 1'b0;
        chk("b2b.count", 32'(c_rdy.size()), 32'd2);
        if (c_rdy.size() == 2) begin
            chk("b2b.cyc0", 32'(c_rdy[0]), 32'd3);
            chk("b2b.cyc1", 32'(c_rdy[1]), 32'd7);
            chk("b2b.word0", w_rdy[0], mem_word(20'd0));
            chk("b2b.word1", w_rdy[1], mem_word(20'd1));
        end
        @(negedge clk);

        // Flush has priority over a request in IDLE.
        bus.req_i = 1'b1;
        bus.flush_i = 1'b1;
        bus.addr_i = 32'h8000_0010;
        @(negedge clk);
        bus.req_i = 1'b0;
        bus.flush_i = 1'b0;
        chk("flush_idle.ce_n", {31'd0, ram_ce_n}, 32'd1);
        @(negedge clk);
        chk("flush_idle.rdy", {31'd0, bus.rdy_o}, 32'd0);

        // Flush in cycle 2 of ACCESS, then a new request in cycle 3.
        bus.req_i = 1'b1;
        bus.addr_i = 32'h8000_0010;
        @(negedge clk);
        bus.req_i = 1'b0;
        chk("flush_acc.c1_ce_n", {31'd0, ram_ce_n}, 32'd0);
        chk("flush_acc.c1_rdy", {31'd0, bus.rdy_o}, 32'd0);
        @(negedge clk);
        chk("flush_acc.c2_ce_n", {31'd0, ram_ce_n}, 32'd0);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        chk("flush_acc.c3_ce_n", {31'd0, ram_ce_n}, 32'd1);
        chk("flush_acc.c3_oe_n", {31'd0, ram_oe_n}, 32'd1);
        chk("flush_acc.c3_rdy", {31'd0, bus.rdy_o}, 32'd0);
        fetch_and_check("flush_acc.refetch", 32'h8000_0014);
        @(negedge clk);

        // Asynchronous reset between edges during ACCESS.
        bus.req_i = 1'b1;
        bus.addr_i = 32'h8000_0020;
        @(negedge clk);
        bus.req_i = 1'b0;
        chk("areset.pre_ce_n", {31'd0, ram_ce_n}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("areset.ce_n", {31'd0, ram_ce_n}, 32'd1);
        chk("areset.oe_n", {31'd0, ram_oe_n}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("areset.post_rdy", {31'd0, bus.rdy_o}, 32'd0);
        fetch_and_check("areset.refetch", 32'h8000_0010);

        // Random fetches against the model.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            int kind;
            kind = int'($urandom_range(0, 4));
            a = BASE + ($urandom_range(0, WORDS - 1) << 2);
            if (kind == 2) a = a | 32'($urandom_range(1, 3));
            if (kind == 3) a = $urandom_range(0, 32'h7FFF_FFFF);
            if (kind == 4) a = 32'h8040_0000 + ($urandom & 32'h3FFF_FFFF);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            fetch_and_check($sformatf("rnd%0d", i), a);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/inst_fetch_sram.md
Name: inst_fetch_sram

Overview:
- Responder side of the instruction-fetch interface. The PC issues byte addresses; this block reads the 32-bit instruction word from base SRAM and returns it with a ready pulse.
- It drives the base SRAM control pins (read-only) and raises a stall so the PC holds its value until the word is delivered.
- It sits between the PC stage and the IF/ID pipeline register.

Parameters:
- WAIT_CYCLES, 2, number of cycles the SRAM is held with ce_n/oe_n low before data is sampled (legal range 1..15).
- BASE_ADDR, 32'h8000_0000, byte address that maps to SRAM word 0.
- RAM_WORDS, 1048576, SRAM depth in 32-bit words (20-bit word address).

Ports:
- clk_i  in  1  single system clock, rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- req_i  in  1  fetch request from the PC stage.
- addr_i  in  32  byte address of the instruction (PC value).
- flush_i  in  1  abort any in-flight fetch (branch/exception redirect).
- rdy_o  out  1  one-cycle pulse: inst_o/err_o valid.
- inst_o  out  32  fetched instruction word.
- err_o  out  1  fetch fault (misaligned or out of range), valid with rdy_o.
- stall_o  out  1  PC must hold; combinational, equals req_i && !rdy_o.
- base_ram_addr_o  out  20  SRAM word address.
- base_ram_data_i  in  32  SRAM read data.
- base_ram_ce_n_o  out  1  SRAM chip enable, active low.
- base_ram_oe_n_o  out  1  SRAM output enable, active low.
- base_ram_we_n_o  out  1  SRAM write enable; constant 1.
- base_ram_be_n_o  out  4  byte enables; constant 4'b0000.

Behaviour:
- Reset is asynchronous and active-low on rst_n_i; clk_i is the only clock.
- Reset values: state=IDLE, rdy_o=0, err_o=0, inst_o=32'h0, base_ram_addr_o=0, ce_n=1, oe_n=1, wait counter=0.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - flush_i=1 keeps IDLE; flush has priority over req_i.
  - req_i=1 with addr_i[1:0]!=0, or addr_i outside [BASE_ADDR, BASE_ADDR+4*RAM_WORDS): go to DONE with err_o=1, inst_o=0. No SRAM access.
  - req_i=1 with a valid address: latch base_ram_addr_o=(addr_i-BASE_ADDR)>>2 (20 bits), ce_n=0, oe_n=0, counter=WAIT_CYCLES-1, go to ACCESS.
- ACCESS:
  - flush_i=1: next state IDLE, ce_n=oe_n=1, no rdy_o.
  - counter!=0: decrement.
  - counter==0: register inst_o<=base_ram_data_i, err_o<=0, ce_n=oe_n=1, go to DONE.
- DONE:
  - rdy_o=1 for exactly one cycle; next state IDLE.
  - flush_i in DONE suppresses rdy_o and discards the word.
  - inst_o holds its value until the next completed fetch.
- Latency, accept edge to rdy_o high:
  - valid address: WAIT_CYCLES+1 cycles.
  - fault: 1 cycle.
- Throughput: a new request is accepted only in IDLE, giving one fetch per WAIT_CYCLES+2 cycles. A req_i held high through DONE is re-accepted in the following IDLE cycle; the PC must update addr_i on the rdy_o cycle.
- addr_i is sampled only at accept; later changes do not affect the in-flight fetch.
- Address arithmetic is 32-bit unsigned. The range check uses a 33-bit compare so BASE_ADDR+4*RAM_WORDS cannot wrap.
- Reset asserted mid-ACCESS forces ce_n/oe_n high immediately (asynchronous).

Decomposition:
- Shared definitions file holds: state encodings (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2), ENABLE/DISABLE levels, ZERO word, NOP word, SRAM address width (20).
- No sub-module; the wait counter is inline.

Test Plan:
- Reset: hold rst_n_i=0 for 3 cycles with req_i=1 -> ce_n=oe_n=1, rdy_o=0, inst_o=0, stall_o=1.
- Aligned fetch, WAIT_CYCLES=2, addr_i=32'h8000_0010, SRAM word 4 = 32'h2402_0005 -> base_ram_addr_o=4, ce_n/oe_n low for cycles 1-2, rdy_o=1 in cycle 3 with inst_o=32'h2402_0005, err_o=0.
- Back-to-back: req_i held high, addr_i stepping 0x8000_0000, 0x8000_0004 on each rdy_o -> rdy_o pulses at cycles 3 and 7, words 0 and 1 returned in order.
- Faults: addr_i=32'h8000_0002 -> rdy_o at cycle 1, err_o=1, inst_o=0, ce_n never low. addr_i=32'h8040_0000 -> same response.
- Flush: flush_i=1 in cycle 2 of an ACCESS -> IDLE at cycle 3, no rdy_o, ce_n high from cycle 3. New request in cycle 3 completes normally.
- Async reset mid-ACCESS: drop rst_n_i between clock edges -> ce_n/oe_n go high before the next edge, and the state is IDLE after release.
